// File: rtl/alu_seq_if.sv
// alu_seq_if: operand / result handshake bundle for the sequential ALU.
//   Request side : in_valid, in_ready, a, b, op
//   Response side: out_valid, out_ready, y, y_hi, carry, zero, overflow, negative
//   master modport = decode/writeback side (drives operands, consumes results)
//   slave modport  = the ALU itself
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_hi;
  logic             carry;
  logic             zero;
  logic             overflow;
  logic             negative;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, y_hi, carry, zero, overflow, negative
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, y_hi, carry, zero, overflow, negative
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU between decode and writeback.
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - alu_seq_if.slave: operands/op in (valid/ready), result and
//          flags out (valid/ready)
// Single-cycle ops register their result on the accept edge; MUL runs a
// WIDTH-step shift-add loop before presenting the product. The result is
// held until the consumer takes it, and only then is a new op accepted.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] y_r, yhi_r;
  logic             carry_r, zero_r, overflow_r, negative_r;

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_eff;
  logic             is_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_o;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] acc_nx, mplier_nx;

  logic             load_alu, start_mul, mul_done;

  // Single-cycle datapath. SUB reuses the adder as a + ~b + 1, so the adder
  // carry-out is "no borrow" and is inverted to report borrow.
  always_comb begin
    shamt  = bus.b[SHW-1:0];
    is_sub = (bus.op == OP_SUB);
    b_eff  = is_sub ? ~bus.b : bus.b;
    sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_y  = '0;
    alu_c  = 1'b0;
    alu_o  = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = is_sub ? ~sum[WIDTH] : sum[WIDTH];
        alu_o = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_y = bus.a & bus.b;
      OP_OR:  alu_y = bus.a | bus.b;
      OP_XOR: alu_y = bus.a ^ bus.b;
      OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL: alu_y = bus.a << shamt;
      OP_SRL: alu_y = bus.a >> shamt;
      OP_SRA: alu_y = $signed(bus.a) >>> shamt;
      default: alu_y = '0;
    endcase
  end

  // One shift-add step: {acc, mplier} acts as a 2*WIDTH product register
  // that shifts right each step, with the multiplier bits draining out
  // of the bottom while product bits fill in from the top.
  always_comb begin
    step_sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nx    = step_sum[WIDTH:1];
    mplier_nx = {step_sum[0], mplier[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and the load strobes for the datapath registers.
  always_comb begin
    state_nx  = state;
    load_alu  = 1'b0;
    start_mul = 1'b0;
    mul_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.op == OP_MUL) begin
            start_mul = 1'b1;
            state_nx  = MUL;
          end else begin
            load_alu = 1'b1;
            state_nx = HOLD;
          end
        end
      end
      MUL: begin
        if (cnt == CW'(1)) begin
          mul_done = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result/flag registers and multiplier working registers. Results only
  // change on a load, so they stay put while idling after a handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r        <= '0;
      yhi_r      <= '0;
      carry_r    <= 1'b0;
      zero_r     <= 1'b0;
      overflow_r <= 1'b0;
      negative_r <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      if (load_alu) begin
        y_r        <= alu_y;
        yhi_r      <= '0;
        carry_r    <= alu_c;
        zero_r     <= (alu_y == '0);
        overflow_r <= alu_o;
        negative_r <= alu_y[WIDTH-1];
      end
      if (start_mul) begin
        mcand  <= bus.a;
        mplier <= bus.b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end
      if (state == MUL) begin
        acc    <= acc_nx;
        mplier <= mplier_nx;
        cnt    <= cnt - CW'(1);
      end
      if (mul_done) begin
        y_r        <= mplier_nx;
        yhi_r      <= acc_nx;
        carry_r    <= 1'b0;
        zero_r     <= ({acc_nx, mplier_nx} == '0);
        overflow_r <= 1'b0;
        negative_r <= acc_nx[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.y         = y_r;
  assign bus.y_hi      = yhi_r;
  assign bus.carry     = carry_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = overflow_r;
  assign bus.negative  = negative_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8).
//   Directed vectors with hand-computed results, MUL timing, backpressure,
//   back-to-back throughput, reset in the middle of a MUL, and a randomized
//   run checked against an arithmetic reference model.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] yhi;
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       o;
    logic       n;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain integer arithmetic on the op definitions.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
    res_t r;
    int ua, ub, sa, sb, sh, t, ts;
    r  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = ub % 8;
    t  = 0;
    ts = 0;
    case (op)
      4'd0: begin
        t   = ua + ub;
        r.y = t[7:0];
        r.c = (t > 255);
        ts  = sa + sb;
        r.o = (ts > 127) || (ts < -128);
      end
      4'd1: begin
        t   = ua - ub;
        r.y = t[7:0];
        r.c = (ua < ub);
        ts  = sa - sb;
        r.o = (ts > 127) || (ts < -128);
      end
      4'd2: r.y = a & b;
      4'd3: r.y = a | b;
      4'd4: r.y = a ^ b;
      4'd5: r.y = (sa < sb) ? 8'd1 : 8'd0;
      4'd6: begin t = ua << sh;  r.y = t[7:0]; end
      4'd7: begin t = ua >> sh;  r.y = t[7:0]; end
      4'd8: begin t = sa >>> sh; r.y = t[7:0]; end
      4'd9: begin
        t     = ua * ub;
        r.y   = t[7:0];
        r.yhi = t[15:8];
      end
      default: r = '0;
    endcase
    r.z = ({r.yhi, r.y} == 16'd0);
    r.n = (op == 4'd9) ? r.yhi[7] : r.y[7];
    return r;
  endfunction

  function automatic res_t observed();
    return {bus.y_hi, bus.y, bus.carry, bus.zero, bus.overflow, bus.negative};
  endfunction

  // Drives one op from IDLE and waits for its result. rise is the number of
  // edges after the accept edge before out_valid is seen (-1 on timeout);
  // hs_ok clears if in_ready was wrong at any point. Releases the result
  // with one edge when out_ready is high.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, output res_t got,
                       output int rise, output bit hs_ok);
    hs_ok        = (bus.in_ready === 1'b1);
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rise = 0;
    while (bus.out_valid !== 1'b1 && rise < 50) begin
      if (bus.in_ready !== 1'b0) hs_ok = 1'b0;
      @(posedge clk);
      #1;
      rise++;
    end
    if (bus.out_valid !== 1'b1) rise = -1;
    if (bus.in_ready !== 1'b0) hs_ok = 1'b0;
    got = observed();
    if (bus.out_ready === 1'b1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== res_t'(0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got res=%h out_valid=%b in_ready=%b, expected res=0 out_valid=0 in_ready=1",
               observed(), bus.out_valid, bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] va   [10] = '{8'h07, 8'hFF, 8'h7F, 8'h00, 8'h08, 8'h80, 8'h01, 8'hA5, 8'hFF, 8'h80};
    logic [7:0] vb   [10] = '{8'h17, 8'hFF, 8'h01, 8'h01, 8'h08, 8'h03, 8'h0B, 8'h08, 8'h12, 8'h7F};
    logic [3:0] vop  [10] = '{4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd8,  4'd6,  4'd7,  4'd12, 4'd5};
    res_t       vexp [10] = '{{8'h00, 8'h1E, 4'b0000},
                              {8'h00, 8'hFE, 4'b1001},
                              {8'h00, 8'h80, 4'b0011},
                              {8'h00, 8'hFF, 4'b1001},
                              {8'h00, 8'h00, 4'b0100},
                              {8'h00, 8'hF0, 4'b0001},
                              {8'h00, 8'h08, 4'b0000},
                              {8'h00, 8'hA5, 4'b0001},
                              {8'h00, 8'h00, 4'b0100},
                              {8'h00, 8'h01, 4'b0000}};
    res_t got;
    int   rise;
    bit   hs_ok;
    for (int i = 0; i < 10; i++) begin
      do_op(va[i], vb[i], vop[i], got, rise, hs_ok);
      checks++;
      if (got !== vexp[i] || rise != 0 || !hs_ok) begin
        errors++;
        $display("[TB] FAIL directed_%0d op=%0d a=%h b=%h: got res=%h rise=%0d hs=%b, expected res=%h rise=0 hs=1",
                 i, vop[i], va[i], vb[i], got, rise, hs_ok, vexp[i]);
      end
    end
  endtask

  task automatic test_mul_timing();
    res_t got;
    int   rise;
    bit   hs_ok;
    do_op(8'hFF, 8'hFF, 4'd9, got, rise, hs_ok);
    checks++;
    if (got !== {8'hFE, 8'h01, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL mul_ff_ff_result: got %h, expected %h", got, {8'hFE, 8'h01, 4'b0001});
    end
    checks++;
    if (rise != 8 || !hs_ok) begin
      errors++;
      $display("[TB] FAIL mul_timing: got rise=%0d hs=%b, expected rise=8 hs=1", rise, hs_ok);
    end
    do_op(8'h00, 8'h5A, 4'd9, got, rise, hs_ok);
    checks++;
    if (got !== {8'h00, 8'h00, 4'b0100} || rise != 8) begin
      errors++;
      $display("[TB] FAIL mul_zero: got res=%h rise=%0d, expected res=%h rise=8",
               got, rise, {8'h00, 8'h00, 4'b0100});
    end
  endtask

  task automatic test_backpressure();
    res_t got, expd;
    int   rise;
    bit   hs_ok;
    expd          = {8'h00, 8'h55, 4'b0000};
    bus.out_ready = 1'b0;
    do_op(8'h5A, 8'h0F, 4'd4, got, rise, hs_ok);
    checks++;
    if (got !== expd || rise != 0 || !hs_ok) begin
      errors++;
      $display("[TB] FAIL backpressure_first: got res=%h rise=%0d hs=%b, expected res=%h rise=0 hs=1",
               got, rise, hs_ok, expd);
    end
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    bus.op       = 4'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== expd || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold_%0d: got res=%h out_valid=%b in_ready=%b, expected res=%h out_valid=1 in_ready=0",
                 i, observed(), bus.out_valid, bus.in_ready, expd);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== expd || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release: got res=%h out_valid=%b in_ready=%b, expected res=%h out_valid=0 in_ready=1",
               observed(), bus.out_valid, bus.in_ready, expd);
    end
  endtask

  task automatic test_back_to_back();
    int   seen;
    res_t expd;
    expd          = model(8'h33, 8'h44, 4'd0);
    seen          = 0;
    bus.a         = 8'h33;
    bus.b         = 8'h44;
    bus.op        = 4'd0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        seen++;
        checks++;
        if (observed() !== expd) begin
          errors++;
          $display("[TB] FAIL back_to_back_result: got %h, expected %h", observed(), expd);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (seen != 5) begin
      errors++;
      $display("[TB] FAIL back_to_back_throughput: got %0d results in 10 cycles, expected 5", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_mul();
    res_t got;
    int   rise;
    bit   hs_ok;
    bus.a        = 8'hC3;
    bus.b        = 8'h9D;
    bus.op       = 4'd9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== res_t'(0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_mul: got res=%h out_valid=%b in_ready=%b, expected res=0 out_valid=0 in_ready=1",
               observed(), bus.out_valid, bus.in_ready);
    end
    rst = 1'b0;
    do_op(8'h01, 8'h01, 4'd0, got, rise, hs_ok);
    checks++;
    if (got !== {8'h00, 8'h02, 4'b0000} || rise != 0 || !hs_ok) begin
      errors++;
      $display("[TB] FAIL after_reset_add: got res=%h rise=%0d hs=%b, expected res=%h rise=0 hs=1",
               got, rise, hs_ok, {8'h00, 8'h02, 4'b0000});
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic [3:0] op;
    res_t       got, expd;
    int         rise;
    bit         hs_ok;
    for (int i = 0; i < 200; i++) begin
      a    = 8'($urandom_range(0, 255));
      b    = 8'($urandom_range(0, 255));
      op   = 4'($urandom_range(0, 15));
      expd = model(a, b, op);
      do_op(a, b, op, got, rise, hs_ok);
      checks++;
      if (got !== expd || rise != ((op == 4'd9) ? 8 : 0) || !hs_ok) begin
        errors++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got res=%h rise=%0d hs=%b, expected res=%h rise=%0d hs=1",
                 i, op, a, b, got, rise, hs_ok, expd, (op == 4'd9) ? 8 : 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_mul_timing();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
